// File: rtl/serial_seq_pkg.sv
// Shared types and default sizing for the serial pattern transmitter and detector benches.
package serial_seq_pkg;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_GAP_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with terminal-count (zero) flag; load has priority over decrement.
module seq_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeated with optional idle gaps.
//   state   | meaning
//   S_IDLE  | waiting for a request, in_ready=1
//   S_SHIFT | presenting pattern bits, one per cycle
//   S_GAP   | idle cycles between repetitions
module serial_pattern_tx
    import serial_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP_W = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pattern,
    input  logic [CNT_W-1:0] in_repeat,
    input  logic [GAP_W-1:0] in_gap,
    output logic             so,
    output logic             so_valid,
    output logic             sof,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_pattern;
    logic [GAP_W-1:0]   r_gap;
    logic               r_so, r_so_valid, r_sof, r_busy, r_done;
    logic               w_so_nxt, w_vld_nxt, w_sof_nxt, w_busy_nxt, w_done_nxt;
    logic               w_idx_load, w_idx_dec, w_gap_load, w_gap_dec, w_rep_load, w_rep_dec;
    logic [IDX_W-1:0]   w_idx, w_idx_m1;
    logic               w_idx_zero, w_gap_zero, w_rep_zero;
    logic [GAP_W-1:0]   w_unused_gap_cnt;
    logic [CNT_W-1:0]   w_unused_rep_cnt;
    logic               w_accept;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_idx_m1 = w_idx - 1'b1;

    seq_down_counter #(.W(IDX_W)) u_idx_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_idx_load),
        .i_load_val (IDX_TOP),
        .i_dec      (w_idx_dec),
        .o_count    (w_idx),
        .o_zero     (w_idx_zero)
    );

    // Gap counter holds remaining gap cycles minus one, so zero marks the last gap cycle.
    seq_down_counter #(.W(GAP_W)) u_gap_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_gap_load),
        .i_load_val (r_gap - 1'b1),
        .i_dec      (w_gap_dec),
        .o_count    (w_unused_gap_cnt),
        .o_zero     (w_gap_zero)
    );

    seq_down_counter #(.W(CNT_W)) u_rep_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_rep_load),
        .i_load_val (in_repeat),
        .i_dec      (w_rep_dec),
        .o_count    (w_unused_rep_cnt),
        .o_zero     (w_rep_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_so_nxt    = 1'b0;
        w_vld_nxt   = 1'b0;
        w_sof_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_idx_load  = 1'b0;
        w_idx_dec   = 1'b0;
        w_gap_load  = 1'b0;
        w_gap_dec   = 1'b0;
        w_rep_load  = 1'b0;
        w_rep_dec   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_SHIFT;
                    w_idx_load  = 1'b1;
                    w_rep_load  = 1'b1;
                    w_so_nxt    = in_pattern[WIDTH-1];
                    w_vld_nxt   = 1'b1;
                    w_sof_nxt   = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_SHIFT: begin
                w_busy_nxt = 1'b1;
                if (!w_idx_zero) begin
                    w_idx_dec = 1'b1;
                    w_so_nxt  = r_pattern[w_idx_m1];
                    w_vld_nxt = 1'b1;
                end else if (w_rep_zero) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_rep_dec = 1'b1;
                    if (r_gap == '0) begin
                        w_idx_load = 1'b1;
                        w_so_nxt   = r_pattern[WIDTH-1];
                        w_vld_nxt  = 1'b1;
                        w_sof_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_GAP;
                        w_gap_load  = 1'b1;
                    end
                end
            end
            S_GAP: begin
                w_busy_nxt = 1'b1;
                if (w_gap_zero) begin
                    w_state_nxt = S_SHIFT;
                    w_idx_load  = 1'b1;
                    w_so_nxt    = r_pattern[WIDTH-1];
                    w_vld_nxt   = 1'b1;
                    w_sof_nxt   = 1'b1;
                end else begin
                    w_gap_dec = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pattern  <= '0;
            r_gap      <= '0;
            r_so       <= 1'b0;
            r_so_valid <= 1'b0;
            r_sof      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_so       <= w_so_nxt;
            r_so_valid <= w_vld_nxt;
            r_sof      <= w_sof_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            if (w_accept) begin
                r_pattern <= in_pattern;
                r_gap     <= in_gap;
            end
        end
    end

    assign in_ready = (r_state == S_IDLE);
    assign so       = r_so;
    assign so_valid = r_so_valid;
    assign sof      = r_sof;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Cycle-accurate scoreboard bench for serial_pattern_tx.
module tb_serial_pattern_tx;
    import serial_seq_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int CW = DEF_CNT_W;
    localparam int GW = DEF_GAP_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_pattern;
    logic [CW-1:0] in_repeat;
    logic [GW-1:0] in_gap;
    logic          so, so_valid, sof, busy, done;

    typedef struct packed {
        logic vld;
        logic so;
        logic sof;
        logic busy;
        logic done;
        logic rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    serial_pattern_tx #(.WIDTH(W), .CNT_W(CW), .GAP_W(GW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pattern (in_pattern),
        .in_repeat  (in_repeat),
        .in_gap     (in_gap),
        .so         (so),
        .so_valid   (so_valid),
        .sof        (sof),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic exp_t observed();
        return '{so_valid, so, sof, busy, done, in_ready};
    endfunction

    // Expected per-cycle outputs for one frame, from cycle 1 through the done cycle.
    task automatic push_frame(input logic [W-1:0] pat, input int r, input int g, input bit idle_after);
        for (int k = 0; k <= r; k++) begin
            for (int b = W - 1; b >= 0; b--)
                exp_q.push_back('{1'b1, pat[b], (b == W - 1), 1'b1, 1'b0, 1'b0});
            if (k < r)
                for (int j = 0; j < g; j++)
                    exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        end
        exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        if (idle_after)
            exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic drive_req(input logic [W-1:0] pat, input int r, input int g);
        @(negedge clk);
        in_valid   = 1'b1;
        in_pattern = pat;
        in_repeat  = CW'(r);
        in_gap     = GW'(g);
    endtask

    task automatic test_reset();
        exp_t o;
        rst_n = 1'b0;
        in_valid = 1'b0; in_pattern = '0; in_repeat = '0; in_gap = '0;
        repeat (2) @(negedge clk);
        o = observed();
        if (o !== exp_t'(6'b000001)) begin
            errors++;
            $display("FAIL reset_hold: got vld/so/sof/busy/done/rdy=%b want 000001", o);
        end
        checks++;
        rst_n = 1'b1;
        @(negedge clk);
        o = observed();
        if (o !== exp_t'(6'b000001)) begin
            errors++;
            $display("FAIL reset_release_idle: got %b want 000001", o);
        end
        checks++;
    endtask

    task automatic test_single();
        exp_t e, o;
        int cyc = 0;
        drive_req(3'b101, 0, 0);
        push_frame(3'b101, 0, 0, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_pattern = W'($urandom);
            cyc++;
            e = exp_q.pop_front();
            o = observed();
            if (o !== e) begin
                errors++;
                $display("FAIL single cyc %0d: got %b want %b", cyc, o, e);
            end
            checks++;
        end
    endtask

    task automatic test_repeat_gap();
        exp_t e, o;
        int cyc = 0;
        drive_req(3'b110, 1, 2);
        push_frame(3'b110, 1, 2, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_gap = GW'($urandom);
            in_repeat = CW'($urandom);
            cyc++;
            e = exp_q.pop_front();
            o = observed();
            if (o !== e) begin
                errors++;
                $display("FAIL repeat_gap cyc %0d: got %b want %b", cyc, o, e);
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, o;
        int cyc = 0;
        drive_req(3'b011, 2, 0);
        push_frame(3'b011, 2, 0, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            cyc++;
            e = exp_q.pop_front();
            o = observed();
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: got %b want %b", cyc, o, e);
            end
            checks++;
        end
    endtask

    task automatic test_busy_handshake();
        exp_t e, o;
        int cyc = 0;
        drive_req(3'b101, 0, 0);
        push_frame(3'b101, 0, 0, 0);
        push_frame(3'b111, 0, 0, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                in_valid = 1'b1; in_pattern = 3'b111; in_repeat = '0; in_gap = '0;
            end
            if (cyc == 5)
                in_valid = 1'b0;
            e = exp_q.pop_front();
            o = observed();
            if (o !== e) begin
                errors++;
                $display("FAIL busy_handshake cyc %0d: got %b want %b", cyc, o, e);
            end
            checks++;
        end
    endtask

    task automatic test_max_counts();
        exp_t e, o;
        int cyc = 0;
        int r = (1 << CW) - 1;
        int g = (1 << GW) - 1;
        drive_req(3'b100, r, g);
        push_frame(3'b100, r, g, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            cyc++;
            e = exp_q.pop_front();
            o = observed();
            if (o !== e) begin
                errors++;
                $display("FAIL max_counts cyc %0d: got %b want %b", cyc, o, e);
            end
            checks++;
        end
    endtask

    task automatic test_random_frames();
        exp_t e, o;
        logic [W-1:0] p;
        int r, g, cyc;
        for (int n = 0; n < 4; n++) begin
            p = W'($urandom_range(0, (1 << W) - 1));
            r = $urandom_range(0, 3);
            g = $urandom_range(0, 3);
            cyc = 0;
            drive_req(p, r, g);
            push_frame(p, r, g, 1);
            while (exp_q.size() > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                cyc++;
                e = exp_q.pop_front();
                o = observed();
                if (o !== e) begin
                    errors++;
                    $display("FAIL random p=%b r=%0d g=%0d cyc %0d: got %b want %b", p, r, g, cyc, o, e);
                end
                checks++;
            end
        end
    endtask

    task automatic test_abort();
        exp_t e, o;
        int cyc = 0;
        drive_req(3'b110, 1, 2);
        @(negedge clk);
        in_valid = 1'b0;
        o = observed();
        if (o !== exp_t'(6'b111100)) begin
            errors++;
            $display("FAIL abort_cyc1: got %b want 111100", o);
        end
        checks++;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        o = observed();
        if (o !== exp_t'(6'b000001)) begin
            errors++;
            $display("FAIL abort_async_clear: got %b want 000001", o);
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            o = observed();
            if (o !== exp_t'(6'b000001)) begin
                errors++;
                $display("FAIL abort_held cyc %0d: got %b want 000001", i, o);
            end
            checks++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || so_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done cyc %0d: got done=%b so_valid=%b want 0 0", i, done, so_valid);
            end
            checks++;
        end
        drive_req(3'b101, 0, 0);
        push_frame(3'b101, 0, 0, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            cyc++;
            e = exp_q.pop_front();
            o = observed();
            if (o !== e) begin
                errors++;
                $display("FAIL abort_recover cyc %0d: got %b want %b", cyc, o, e);
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat_gap();
        test_back_to_back();
        test_busy_handshake();
        test_max_counts();
        test_random_frames();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
